// File: rtl/maindec_mc.sv
// Multicycle LEGv8 main controller.
// Latches the opcode in FETCH, classifies it, and sequences
// FETCH -> DECODE -> EXEC -> MEM -> WB. Data-memory accesses wait on
// mem_ready, with a timeout counter that reports a memory fault.
module maindec_mc #(
  parameter int OPW         = 11,
  parameter bit EN_CBNZ     = 1'b1,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  input  logic [OPW-1:0] Op,
  input  logic           mem_ready,
  output logic           Reg2Loc,
  output logic           ALUSrc,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           Branch,
  output logic [1:0]     ALUOp,
  output logic           BranchNZ,
  output logic           UncondBranch,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           busy,
  output logic           illegal,
  output logic           mem_fault,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ILL  = 3'd0,
    C_LDUR = 3'd1,
    C_STUR = 3'd2,
    C_CBZ  = 3'd3,
    C_CBNZ = 3'd4,
    C_RT   = 3'd5,
    C_ADDI = 3'd6,
    C_B    = 3'd7
  } cls_t;

  state_t           r_state;
  state_t           w_next;
  logic [OPW-1:0]   r_op;
  logic [TO_W-1:0]  r_cnt;
  logic [10:0]      w_op11;
  cls_t             w_cls;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  logic       w_reg2loc, w_alusrc, w_memtoreg, w_regwrite;
  logic       w_memread, w_memwrite, w_branch, w_bnz, w_ub;
  logic       w_irwrite, w_pcwrite, w_illegal, w_fault;
  logic [1:0] w_aluop;

  assign w_op11 = r_op[10:0];

  // Classify the latched opcode; CBNZ is trapped when not enabled.
  always_comb begin
    w_cls = C_ILL;
    casez (w_op11)
      11'b11111000010: w_cls = C_LDUR;
      11'b11111000000: w_cls = C_STUR;
      11'b10110100???: w_cls = C_CBZ;
      11'b10110101???: begin
        if (EN_CBNZ) begin
          w_cls = C_CBNZ;
        end else begin
          w_cls = C_ILL;
        end
      end
      11'b10001011000: w_cls = C_RT;
      11'b11001011000: w_cls = C_RT;
      11'b10001010000: w_cls = C_RT;
      11'b10101010000: w_cls = C_RT;
      11'b1001000100?: w_cls = C_ADDI;
      11'b000101?????: w_cls = C_B;
      default:         w_cls = C_ILL;
    endcase
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    w_next     = r_state;
    w_reg2loc  = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = 2'b00;
    w_bnz      = 1'b0;
    w_ub       = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_illegal  = 1'b0;
    w_fault    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;

    // Class controls are held from EXEC until the instruction retires.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (w_cls)
        C_LDUR: w_alusrc = 1'b1;
        C_STUR: begin
          w_alusrc  = 1'b1;
          w_reg2loc = 1'b1;
        end
        C_CBZ, C_CBNZ: begin
          w_reg2loc = 1'b1;
          w_aluop   = 2'b01;
        end
        C_RT: w_aluop = 2'b10;
        C_ADDI: begin
          w_reg2loc = 1'b1;
          w_alusrc  = 1'b1;
          w_aluop   = 2'b10;
        end
        default: w_aluop = 2'b00;
      endcase
    end else begin
      w_aluop = 2'b00;
    end

    case (r_state)
      S_FETCH: begin
        w_irwrite = instr_valid;
        if (instr_valid) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_cls == C_ILL) begin
          w_illegal = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_cnt_clr = 1'b1;
        case (w_cls)
          C_RT, C_ADDI:   w_next = S_WB;
          C_LDUR, C_STUR: w_next = S_MEM;
          C_CBZ: begin
            w_branch  = 1'b1;
            w_pcwrite = 1'b1;
            w_next    = S_FETCH;
          end
          C_CBNZ: begin
            w_branch  = 1'b1;
            w_bnz     = 1'b1;
            w_pcwrite = 1'b1;
            w_next    = S_FETCH;
          end
          C_B: begin
            w_ub      = 1'b1;
            w_pcwrite = 1'b1;
            w_next    = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_memread  = (w_cls == C_LDUR);
        w_memwrite = (w_cls == C_STUR);
        // A ready response wins over a timeout in the same cycle.
        if (mem_ready) begin
          if (w_cls == C_LDUR) begin
            w_next = S_WB;
          end else begin
            w_pcwrite = 1'b1;
            w_next    = S_FETCH;
          end
        end else if (r_cnt == TO_W'(MEM_TIMEOUT)) begin
          w_fault = 1'b1;
          w_next  = S_FETCH;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_pcwrite  = 1'b1;
        w_memtoreg = (w_cls == C_LDUR);
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode latch: Op is only sampled when a fetch is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= '0;
    end else if (r_state == S_FETCH && instr_valid) begin
      r_op <= Op;
    end else begin
      r_op <= r_op;
    end
  end

  // Memory timeout counter: cleared entering MEM, counts idle MEM cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + TO_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Every strobe is forced low while reset is asserted.
  assign Reg2Loc      = w_reg2loc  & ~reset;
  assign ALUSrc       = w_alusrc   & ~reset;
  assign MemtoReg     = w_memtoreg & ~reset;
  assign RegWrite     = w_regwrite & ~reset;
  assign MemRead      = w_memread  & ~reset;
  assign MemWrite     = w_memwrite & ~reset;
  assign Branch       = w_branch   & ~reset;
  assign ALUOp        = reset ? 2'b00 : w_aluop;
  assign BranchNZ     = w_bnz      & ~reset;
  assign UncondBranch = w_ub       & ~reset;
  assign IRWrite      = w_irwrite  & ~reset;
  assign PCWrite      = w_pcwrite  & ~reset;
  assign illegal      = w_illegal  & ~reset;
  assign mem_fault    = w_fault    & ~reset;
  assign busy         = (r_state != S_FETCH);
  assign state        = r_state;

endmodule

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
- Multicycle LEGv8 main controller. It is the sequential, parametrised successor of the single-cycle main decoder.
- Latches the 11-bit opcode, classifies it, then steps FETCH→DECODE→EXEC→MEM→WB.
- Drives datapath control per state and waits on a data-memory ready handshake guarded by a timeout counter.
- Adds CBNZ, unconditional B, illegal-opcode trapping and memory-fault reporting.

Parameters:
- OPW, 11, opcode field width; opcode patterns below occupy bits [10:0].
- EN_CBNZ, 1, 1 decodes CBNZ; 0 traps it as illegal.
- TO_W, 4, width of the memory-timeout counter.
- MEM_TIMEOUT, 15, maximum MEM-state cycles without mem_ready before a fault; must be less than 2^TO_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-high reset.
- instr_valid  in  1  fetched instruction word is available on Op.
- Op  in  OPW  instruction opcode bits [31:21].
- mem_ready  in  1  data memory has completed the access this cycle.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- ALUOp  out  2  ALU-decoder class.
- BranchNZ  out  1  branch taken on non-zero (CBNZ).
- UncondBranch  out  1  B instruction.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  update the PC this cycle.
- busy  out  1  state is not FETCH.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- mem_fault  out  1  one-cycle pulse on memory timeout.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

Behaviour:
- Reset (asynchronous): state=FETCH, op_q=0, timeout counter=0. Every output is 0 while reset is high, including IRWrite.
- Decode on op_q (z = don't care):
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ 10110100zzz
  - CBNZ 10110101zzz
  - ADD 10001011000
  - ADDI 1001000100z
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - B 000101zzzzz
  - Anything else is illegal.
- Per-class controls, held from EXEC through the last cycle of the instruction and 0 in FETCH/DECODE:
  - LDUR/STUR: ALUSrc=1, ALUOp=00.
  - STUR: Reg2Loc=1.
  - CBZ/CBNZ: Reg2Loc=1, ALUOp=01.
  - ADD/SUB/AND/ORR: ALUOp=10.
  - ADDI: Reg2Loc=1, ALUSrc=1, ALUOp=10.
  - B: ALUOp=00.
- FETCH:
  - IRWrite = instr_valid.
  - On instr_valid, op_q<=Op and go to DECODE; otherwise stay.
- DECODE:
  - Illegal opcode: illegal=1, PCWrite=1 (skip the instruction), go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - R-type/ADDI → WB.
  - LDUR/STUR → MEM; counter cleared.
  - CBZ: Branch=1, PCWrite=1, → FETCH.
  - CBNZ: Branch=1, BranchNZ=1, PCWrite=1, → FETCH.
  - B: UncondBranch=1, PCWrite=1, → FETCH.
- MEM:
  - MemRead=1 (LDUR) or MemWrite=1 (STUR), held until exit.
  - mem_ready=1: LDUR → WB; STUR drives PCWrite=1 and → FETCH.
  - mem_ready=0 and counter==MEM_TIMEOUT: mem_fault=1, PCWrite=0, → FETCH.
  - Otherwise counter increments.
  - mem_ready has priority over timeout in the same cycle.
- WB:
  - RegWrite=1, PCWrite=1, MemtoReg=1 for LDUR only, → FETCH.
- Latency, FETCH-accept to return to FETCH with zero-wait memory: branch/B 3 cycles, R-type/ADDI 4, STUR 4, LDUR 5.
- Outputs are combinational functions of state and op_q, plus instr_valid (IRWrite) and mem_ready (PCWrite in MEM).
- Op is sampled only in FETCH; Op changes in any other state are ignored.
- Reset mid-instruction aborts immediately with no further strobes.
- busy = (state != FETCH).

Test Plan:
- Reset high for 2 cycles with instr_valid=1 → all outputs 0, state=0. After release, first edge latches Op.
- ADD 10001011000, instr_valid=1 → states 0,1,2,4,0. RegWrite=1 and PCWrite=1 only in WB. ALUOp=10 in EXEC and WB.
- LDUR 11111000010, mem_ready low for 3 cycles then high → MemRead=1 for 4 MEM cycles. WB has MemtoReg=1, RegWrite=1. No mem_fault.
- STUR 11111000000, mem_ready held 0 → mem_fault pulses once on the 16th MEM cycle, PCWrite=0, state returns to 0, MemWrite deasserts.
- CBNZ 10110101011 with EN_CBNZ=1 → EXEC drives Branch=1, BranchNZ=1, PCWrite=1, Reg2Loc=1, ALUOp=01. With EN_CBNZ=0 → illegal=1 in DECODE, state 0 next.
- B 00010100000 followed by opcode 11111111111 → B: UncondBranch=1 in EXEC, 3-cycle latency. Second opcode: illegal pulse, no RegWrite/MemWrite ever asserted.
